// File: rtl/ahci_dma_rd_sched_pkg.sv
// ahci_dma_rd_sched_pkg
// Shared definitions for the AHCI DMA read/write burst schedulers:
//   - state_t    : scheduler state encoding (IDLE/CALC/ADDR/DRAIN)
//   - MAX_BURST  : longest AXI burst in QWORD beats
//   - PAGE_QW    : QWORDs in a 4 KB page; bursts never cross this boundary
package ahci_dma_rd_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      ADDR  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam int MAX_BURST = 16;
   localparam int PAGE_QW   = 512;

endpackage

// File: rtl/ahci_dma_burst_len.sv
// ahci_dma_burst_len
// Combinational burst sizing: len = min(MAX_BURST, remaining, PAGE_QW - qw_off).
// Shared by the read- and write-side DMA schedulers.
// Ports:
//   remaining  in  WCNT_BITS  QWORDs left in the region
//   qw_off     in  9          QWORD offset of the next burst inside its 4 KB page
//   len        out 5          burst length in QWORDs (0 only when remaining = 0)
module ahci_dma_burst_len
   import ahci_dma_rd_sched_pkg::*;
#(
   parameter int WCNT_BITS = 21
) (
   input  logic [WCNT_BITS-1:0] remaining,
   input  logic [8:0]           qw_off,
   output logic [4:0]           len
);

   logic [9:0]           page_room;
   logic [WCNT_BITS-1:0] cap;

   // Clip to the burst limit first, then to the room left in the page.
   always_comb begin
      page_room = 10'(PAGE_QW) - {1'b0, qw_off};
      if (remaining < WCNT_BITS'(MAX_BURST)) begin
         cap = remaining;
      end else begin
         cap = WCNT_BITS'(MAX_BURST);
      end
      if (WCNT_BITS'(page_room) < cap) begin
         len = page_room[4:0];
      end else begin
         len = cap[4:0];
      end
   end

endmodule

// File: rtl/ahci_dma_rd_sched.sv
// ahci_dma_rd_sched
// Read-side DMA burst scheduler (hclk domain). Splits one PRD region
// (DWORD address + DWORD count) into QWORD-aligned AXI read bursts of at most
// 16 beats that never cross a 4 KB page, throttled by FIFO space credits and
// an outstanding-burst limit. Hands the FIFO its word count and first-word
// skip, and reports region completion.
// Optional feature macro: AHCI_DMA_RD_SCHED_STAT_EN adds stat_bursts/stat_stall.
// Ports:
//   hclk, hrst              clock, asynchronous active-high reset
//   prd_start/addr/dwords   region request (accepted only when idle)
//   abort                   stop further AR issue (level or pulse)
//   busy, done, done_err    status; done_err=1 means the region was aborted
//   fifo_cfg/wcnt/skip      FIFO configuration pulse and values
//   ar_addr/len/valid/ready AXI read address channel
//   r_beat, r_last          R beat accepted / last beat of a burst
//   fifo_qw_re              one QWORD drained from the FIFO (credit return)
//   stat_bursts, stat_stall wrapping statistics (only with the macro)
module ahci_dma_rd_sched
   import ahci_dma_rd_sched_pkg::*;
#(
   parameter int WCNT_BITS  = 21,
   parameter int FIFO_DEPTH = 64,
   parameter int MAX_OUTST  = 4
) (
   input  logic                 hclk,
   input  logic                 hrst,
   input  logic                 prd_start,
   input  logic [29:0]          prd_addr,
   input  logic [WCNT_BITS-1:0] prd_dwords,
   input  logic                 abort,
   output logic                 busy,
   output logic                 done,
   output logic                 done_err,
   output logic                 fifo_cfg,
   output logic [WCNT_BITS-1:0] fifo_wcnt,
   output logic                 fifo_skip,
   output logic [31:0]          ar_addr,
   output logic [3:0]           ar_len,
   output logic                 ar_valid,
   input  logic                 ar_ready,
   input  logic                 r_beat,
   input  logic                 r_last,
   input  logic                 fifo_qw_re
`ifdef AHCI_DMA_RD_SCHED_STAT_EN
   ,
   output logic [15:0]          stat_bursts,
   output logic [15:0]          stat_stall
`endif
);

   localparam int CRED_W  = $clog2(FIFO_DEPTH + 1);
   localparam int CSUM_W  = CRED_W + 1;
   localparam int OUTST_W = $clog2(MAX_OUTST + 1);

   state_t               state;
   state_t               state_nxt;
   logic [28:0]          qw_addr;
   logic [WCNT_BITS-1:0] remaining;
   logic [WCNT_BITS-1:0] region_qw;
   logic [CRED_W-1:0]    credit;
   logic [CRED_W-1:0]    credit_nxt;
   logic [CSUM_W-1:0]    credit_sum;
   logic [OUTST_W-1:0]   outst;
   logic [OUTST_W-1:0]   outst_nxt;
   logic [30:0]          last_dw;
   logic [29:0]          qw_last;
   logic [4:0]           len;
   logic [4:0]           burst_qw;
   logic                 aborted;
   logic                 aborted_nxt;
   logic                 accept;
   logic                 ar_hs;
   logic                 r_dec;
   logic                 load_ar;
   logic                 finish;

   ahci_dma_burst_len #(.WCNT_BITS(WCNT_BITS)) u_burst_len (
      .remaining (remaining),
      .qw_off    (qw_addr[8:0]),
      .len       (len)
   );

   // Region size in QWORDs from the request; a zero DWORD count means nothing to move.
   always_comb begin
      last_dw = {1'b0, prd_addr} + 31'(prd_dwords) - 31'd1;
      qw_last = 30'(last_dw >> 1);
      if (prd_dwords == {WCNT_BITS{1'b0}}) begin
         region_qw = {WCNT_BITS{1'b0}};
      end else begin
         region_qw = WCNT_BITS'(qw_last - {1'b0, prd_addr[29:1]} + 30'd1);
      end
   end

   // Handshakes and next values of the credit/outstanding counters (inc and dec net out).
   always_comb begin
      accept      = (state == IDLE) && prd_start;
      ar_hs       = ar_valid && ar_ready;
      r_dec       = r_beat && r_last && (outst != {OUTST_W{1'b0}});
      burst_qw    = {1'b0, ar_len} + 5'd1;
      aborted_nxt = aborted || (abort && ((state == CALC) || (state == ADDR)));
      outst_nxt   = outst + OUTST_W'(ar_hs) - OUTST_W'(r_dec);
      credit_sum  = CSUM_W'(credit) + CSUM_W'(fifo_qw_re)
                    - (ar_hs ? CSUM_W'(burst_qw) : {CSUM_W{1'b0}});
      if (credit_sum > CSUM_W'(FIFO_DEPTH)) begin
         credit_nxt = CRED_W'(FIFO_DEPTH);
      end else begin
         credit_nxt = credit_sum[CRED_W-1:0];
      end
   end

   // Next-state logic. Leaving CALC towards DRAIN with nothing in flight
   // takes the DRAIN exit immediately, so an empty region finishes in cycle 2.
   always_comb begin
      state_nxt = state;
      load_ar   = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (prd_start) begin
               state_nxt = CALC;
            end else begin
               state_nxt = IDLE;
            end
         end
         CALC: begin
            if (aborted_nxt || (remaining == {WCNT_BITS{1'b0}})) begin
               if (outst_nxt == {OUTST_W{1'b0}}) begin
                  state_nxt = IDLE;
                  finish    = 1'b1;
               end else begin
                  state_nxt = DRAIN;
               end
            end else if ((CSUM_W'(credit) >= CSUM_W'(len)) &&
                         (outst < OUTST_W'(MAX_OUTST))) begin
               state_nxt = ADDR;
               load_ar   = 1'b1;
            end else begin
               state_nxt = CALC;
            end
         end
         ADDR: begin
            // An issued AR must complete before abort can take effect.
            if (ar_hs) begin
               if (aborted_nxt) begin
                  state_nxt = DRAIN;
               end else begin
                  state_nxt = CALC;
               end
            end else begin
               state_nxt = ADDR;
            end
         end
         DRAIN: begin
            if (outst_nxt == {OUTST_W{1'b0}}) begin
               state_nxt = IDLE;
               finish    = 1'b1;
            end else begin
               state_nxt = DRAIN;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge hclk or posedge hrst) begin
      if (hrst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Counters persist across regions: the FIFO may still hold earlier data.
   always_ff @(posedge hclk or posedge hrst) begin
      if (hrst) begin
         credit <= CRED_W'(FIFO_DEPTH);
         outst  <= {OUTST_W{1'b0}};
      end else begin
         credit <= credit_nxt;
         outst  <= outst_nxt;
      end
   end

   // Region walk, AR channel and status outputs.
   always_ff @(posedge hclk or posedge hrst) begin
      if (hrst) begin
         qw_addr   <= 29'd0;
         remaining <= {WCNT_BITS{1'b0}};
         aborted   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         done_err  <= 1'b0;
         fifo_cfg  <= 1'b0;
         fifo_wcnt <= {WCNT_BITS{1'b0}};
         fifo_skip <= 1'b0;
         ar_addr   <= 32'd0;
         ar_len    <= 4'd0;
         ar_valid  <= 1'b0;
      end else begin
         fifo_cfg <= accept;
         done     <= finish;
         if (accept) begin
            qw_addr   <= prd_addr[29:1];
            remaining <= region_qw;
            fifo_wcnt <= prd_dwords;
            fifo_skip <= prd_addr[0];
            aborted   <= 1'b0;
            busy      <= 1'b1;
            done_err  <= 1'b0;
         end else begin
            aborted <= aborted_nxt;
            if (ar_hs) begin
               qw_addr   <= qw_addr + 29'(burst_qw);
               remaining <= remaining - WCNT_BITS'(burst_qw);
            end
            if (finish) begin
               busy     <= 1'b0;
               done_err <= aborted_nxt;
            end
         end
         if (load_ar) begin
            ar_valid <= 1'b1;
            ar_addr  <= {qw_addr, 3'b000};
            ar_len   <= 4'(len - 5'd1);
         end else if (ar_hs) begin
            ar_valid <= 1'b0;
         end
      end
   end

`ifdef AHCI_DMA_RD_SCHED_STAT_EN
   logic stall;

   // CALC only loops on itself when credit or the outstanding limit blocks issue.
   always_comb begin
      stall = (state == CALC) && (state_nxt == CALC);
   end

   // Wrapping statistics counters.
   always_ff @(posedge hclk or posedge hrst) begin
      if (hrst) begin
         stat_bursts <= 16'd0;
         stat_stall  <= 16'd0;
      end else begin
         stat_bursts <= stat_bursts + 16'(ar_hs);
         stat_stall  <= stat_stall + 16'(stall);
      end
   end
`endif

endmodule

// File: tb/tb_ahci_dma_rd_sched.sv
module tb_ahci_dma_rd_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        prd_start, s_prd_start;
   logic [29:0] prd_addr;
   logic [20:0] prd_dwords;
   logic        abort, ar_ready, r_beat, r_last, fifo_qw_re;

   logic        busy, done, done_err, fifo_cfg, fifo_skip, ar_valid;
   logic [20:0] fifo_wcnt;
   logic [31:0] ar_addr;
   logic [3:0]  ar_len;

   logic        s_busy, s_done, s_done_err, s_fifo_cfg, s_fifo_skip, s_ar_valid;
   logic [20:0] s_fifo_wcnt;
   logic [31:0] s_ar_addr;
   logic [3:0]  s_ar_len;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ahci_dma_rd_sched #(.WCNT_BITS(21), .FIFO_DEPTH(64), .MAX_OUTST(4)) dut (
      .hclk(clk), .hrst(rst), .prd_start(prd_start), .prd_addr(prd_addr),
      .prd_dwords(prd_dwords), .abort(abort), .busy(busy), .done(done),
      .done_err(done_err), .fifo_cfg(fifo_cfg), .fifo_wcnt(fifo_wcnt),
      .fifo_skip(fifo_skip), .ar_addr(ar_addr), .ar_len(ar_len),
      .ar_valid(ar_valid), .ar_ready(ar_ready), .r_beat(r_beat),
      .r_last(r_last), .fifo_qw_re(fifo_qw_re)
   );

   ahci_dma_rd_sched #(.WCNT_BITS(21), .FIFO_DEPTH(16), .MAX_OUTST(4)) dut16 (
      .hclk(clk), .hrst(rst), .prd_start(s_prd_start), .prd_addr(prd_addr),
      .prd_dwords(prd_dwords), .abort(abort), .busy(s_busy), .done(s_done),
      .done_err(s_done_err), .fifo_cfg(s_fifo_cfg), .fifo_wcnt(s_fifo_wcnt),
      .fifo_skip(s_fifo_skip), .ar_addr(s_ar_addr), .ar_len(s_ar_len),
      .ar_valid(s_ar_valid), .ar_ready(ar_ready), .r_beat(r_beat),
      .r_last(r_last), .fifo_qw_re(fifo_qw_re)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // n R beats, r_last on the final one; returns just after the edge that took it.
   task automatic send_burst(input int n);
      for (int i = 0; i < n; i++) begin
         r_beat = 1'b1;
         r_last = (i == n - 1);
         step();
      end
      r_beat = 1'b0;
      r_last = 1'b0;
   endtask

   task automatic pulse_re(input int n);
      for (int i = 0; i < n; i++) begin
         fifo_qw_re = 1'b1;
         step();
      end
      fifo_qw_re = 1'b0;
   endtask

   initial begin
      rst = 1'b1; prd_start = 1'b0; s_prd_start = 1'b0; prd_addr = 30'd0;
      prd_dwords = 21'd0; abort = 1'b0; ar_ready = 1'b0; r_beat = 1'b0;
      r_last = 1'b0; fifo_qw_re = 1'b0;
      step(); step();
      chk("rst_busy",     32'(busy),      32'd0);
      chk("rst_done",     32'(done),      32'd0);
      chk("rst_done_err", 32'(done_err),  32'd0);
      chk("rst_cfg",      32'(fifo_cfg),  32'd0);
      chk("rst_wcnt",     32'(fifo_wcnt), 32'd0);
      chk("rst_skip",     32'(fifo_skip), 32'd0);
      chk("rst_arvalid",  32'(ar_valid),  32'd0);
      chk("rst_araddr",   ar_addr,        32'd0);
      chk("rst_arlen",    32'(ar_len),    32'd0);
      rst = 1'b0; ar_ready = 1'b1;
      step();

      // 64 DWORDs at 0x1000: two full 16-beat bursts
      prd_addr = 30'h400; prd_dwords = 21'd64; prd_start = 1'b1;
      step(); prd_start = 1'b0;
      chk("t1_cfg",  32'(fifo_cfg),  32'd1);
      chk("t1_wcnt", 32'(fifo_wcnt), 32'd64);
      chk("t1_skip", 32'(fifo_skip), 32'd0);
      chk("t1_busy", 32'(busy),      32'd1);
      chk("t1_noar", 32'(ar_valid),  32'd0);
      step();
      chk("t1_ar0_v", 32'(ar_valid), 32'd1);
      chk("t1_ar0_a", ar_addr,       32'h1000);
      chk("t1_ar0_l", 32'(ar_len),   32'd15);
      step();
      chk("t1_gap",   32'(ar_valid), 32'd0);
      step();
      chk("t1_ar1_v", 32'(ar_valid), 32'd1);
      chk("t1_ar1_a", ar_addr,       32'h1080);
      chk("t1_ar1_l", 32'(ar_len),   32'd15);
      step();
      chk("t1_ar1_end", 32'(ar_valid), 32'd0);
      send_burst(16);
      chk("t1_nodone_mid", 32'(done), 32'd0);
      chk("t1_busy_mid",   32'(busy), 32'd1);
      send_burst(16);
      chk("t1_done",     32'(done),     32'd1);
      chk("t1_done_err", 32'(done_err), 32'd0);
      chk("t1_busy_off", 32'(busy),     32'd0);
      step();
      chk("t1_done_pulse", 32'(done), 32'd0);

      // 8 DWORDs at 0xFF8: page split into 1 + 3 QWORDs
      prd_addr = 30'h3FE; prd_dwords = 21'd8; prd_start = 1'b1;
      step(); prd_start = 1'b0;
      chk("t2_cfg",  32'(fifo_cfg),  32'd1);
      chk("t2_wcnt", 32'(fifo_wcnt), 32'd8);
      step();
      chk("t2_ar0_v", 32'(ar_valid), 32'd1);
      chk("t2_ar0_a", ar_addr,       32'h0FF8);
      chk("t2_ar0_l", 32'(ar_len),   32'd0);
      step();
      chk("t2_gap",   32'(ar_valid), 32'd0);
      step();
      chk("t2_ar1_v", 32'(ar_valid), 32'd1);
      chk("t2_ar1_a", ar_addr,       32'h1000);
      chk("t2_ar1_l", 32'(ar_len),   32'd2);
      step();
      send_burst(1);
      chk("t2_nodone_mid", 32'(done), 32'd0);
      send_burst(3);
      chk("t2_done",     32'(done),     32'd1);
      chk("t2_done_err", 32'(done_err), 32'd0);
      step();

      // 3 DWORDs at 0x1004: skip first DWORD, one 2-beat burst
      prd_addr = 30'h401; prd_dwords = 21'd3; prd_start = 1'b1;
      step(); prd_start = 1'b0;
      chk("t3_cfg",  32'(fifo_cfg),  32'd1);
      chk("t3_skip", 32'(fifo_skip), 32'd1);
      chk("t3_wcnt", 32'(fifo_wcnt), 32'd3);
      step();
      chk("t3_ar_v", 32'(ar_valid), 32'd1);
      chk("t3_ar_a", ar_addr,       32'h1000);
      chk("t3_ar_l", 32'(ar_len),   32'd1);
      step(); step();
      chk("t3_single", 32'(ar_valid), 32'd0);
      send_burst(2);
      chk("t3_done", 32'(done), 32'd1);
      step();

      // Depth-16 instance: credit stays clamped at 16 while idle
      pulse_re(5);
      prd_addr = 30'h800; prd_dwords = 21'd128; s_prd_start = 1'b1;
      step(); s_prd_start = 1'b0;
      chk("t4_cfg",  32'(s_fifo_cfg),  32'd1);
      chk("t4_wcnt", 32'(s_fifo_wcnt), 32'd128);
      chk("t4_skip", 32'(s_fifo_skip), 32'd0);
      chk("t4_busy", 32'(s_busy),      32'd1);
      step();
      chk("t4_ar0_v", 32'(s_ar_valid), 32'd1);
      chk("t4_ar0_a", s_ar_addr,       32'h2000);
      chk("t4_ar0_l", 32'(s_ar_len),   32'd15);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t4_nocredit", 32'(s_ar_valid), 32'd0);
      end
      pulse_re(11);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t4_credit11", 32'(s_ar_valid), 32'd0);
      end
      pulse_re(5);
      chk("t4_credit16_calc", 32'(s_ar_valid), 32'd0);
      step();
      chk("t4_ar1_v", 32'(s_ar_valid), 32'd1);
      chk("t4_ar1_a", s_ar_addr,       32'h2080);
      chk("t4_ar1_l", 32'(s_ar_len),   32'd15);
      chk("t4_nodone",    32'(s_done),     32'd0);
      chk("t4_nodoneerr", 32'(s_done_err), 32'd0);
      step();

      // Abort pulse while AR is stalled by ar_ready = 0
      ar_ready = 1'b0;
      prd_addr = 30'h800; prd_dwords = 21'd64; prd_start = 1'b1;
      step(); prd_start = 1'b0;
      chk("t5_cfg", 32'(fifo_cfg), 32'd1);
      step();
      chk("t5_ar_v", 32'(ar_valid), 32'd1);
      chk("t5_ar_a", ar_addr,       32'h2000);
      chk("t5_ar_l", 32'(ar_len),   32'd15);
      abort = 1'b1;
      step(); abort = 1'b0;
      chk("t5_hold_v", 32'(ar_valid), 32'd1);
      chk("t5_hold_a", ar_addr,       32'h2000);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t5_hold_v", 32'(ar_valid), 32'd1);
         chk("t5_hold_a", ar_addr,       32'h2000);
         chk("t5_hold_l", 32'(ar_len),   32'd15);
      end
      ar_ready = 1'b1;
      step();
      chk("t5_hs", 32'(ar_valid), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t5_noissue", 32'(ar_valid), 32'd0);
         chk("t5_busy",    32'(busy),     32'd1);
      end
      prd_dwords = 21'd0; prd_start = 1'b1;
      step(); prd_start = 1'b0;
      chk("t5_ignore_cfg",  32'(fifo_cfg),  32'd0);
      chk("t5_ignore_wcnt", 32'(fifo_wcnt), 32'd64);
      send_burst(16);
      chk("t5_done",     32'(done),     32'd1);
      chk("t5_done_err", 32'(done_err), 32'd1);
      chk("t5_busy_off", 32'(busy),     32'd0);
      step();
      chk("t5_done_pulse", 32'(done),     32'd0);
      chk("t5_err_latch",  32'(done_err), 32'd1);

      // Zero-length region; a second start while busy is ignored
      prd_addr = 30'h123; prd_dwords = 21'd0; prd_start = 1'b1;
      step();
      chk("t6_cfg",  32'(fifo_cfg),  32'd1);
      chk("t6_wcnt", 32'(fifo_wcnt), 32'd0);
      chk("t6_busy", 32'(busy),      32'd1);
      chk("t6_nodone", 32'(done),    32'd0);
      prd_dwords = 21'd5;
      step(); prd_start = 1'b0;
      chk("t6_done",     32'(done),      32'd1);
      chk("t6_done_err", 32'(done_err),  32'd0);
      chk("t6_busy_off", 32'(busy),      32'd0);
      chk("t6_noar",     32'(ar_valid),  32'd0);
      chk("t6_ignored",  32'(fifo_cfg),  32'd0);
      chk("t6_wcnt_kept", 32'(fifo_wcnt), 32'd0);
      step();
      chk("t6_done_pulse", 32'(done), 32'd0);
      chk("t6_idle_cfg",   32'(fifo_cfg), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
